// File: rtl/bullet_sprite_ctrl.sv
// Purpose: single-bullet lifetime FSM (fire, per-frame climb, retire) plus sprite ROM address/pixel-hit generation.
// Latency: position updates on the sampling edge; read_address 1 cycle after DrawX/DrawY, is_bullet 2 cycles (aligned with ROM data_Out).
// Backpressure: none; every input is sampled each cycle and fire is dropped while a bullet is in flight.
module bullet_sprite_ctrl #(
    parameter int SPR_W = 8,
    parameter int SPR_H = 8,
    parameter int STEP  = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic        fire,
    input  logic [9:0]  fire_x,
    input  logic [9:0]  fire_y,
    input  logic        hit,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic        busy,
    output logic [9:0]  bullet_x,
    output logic [9:0]  bullet_y,
    output logic [18:0] read_address,
    output logic        is_bullet
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] FLYING = 1'b1;

    // Parameters sized to the datapaths they are compared/combined with.
    localparam logic [9:0]  SPR_W10 = 10'(SPR_W);
    localparam logic [9:0]  SPR_H10 = 10'(SPR_H);
    localparam logic [9:0]  STEP10  = 10'(STEP);
    localparam logic [18:0] SPR_W19 = 19'(SPR_W);

    logic [0:0]  state;
    logic        fc_q;
    logic        tick;
    logic [9:0]  dx;
    logic [9:0]  dy;
    logic        inbox;
    logic [18:0] addr_next;
    logic        inbox_q1;

    assign busy = (state == FLYING);

    // One tick per rising edge of the frame strobe.
    assign tick = frame_clk & ~fc_q;

    // Sprite-relative offsets; pixels left of/above the sprite wrap large and fail the box test.
    always_comb begin
        dx        = DrawX - bullet_x;
        dy        = DrawY - bullet_y;
        inbox     = busy & (dx < SPR_W10) & (dy < SPR_H10);
        addr_next = '0;
        if (inbox) begin
            addr_next = 19'(dy) * SPR_W19 + 19'(dx);
        end
    end

    // Frame strobe history for edge detection.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fc_q <= 1'b0;
        end else begin
            fc_q <= frame_clk;
        end
    end

    // Bullet lifetime: launch from IDLE; in flight, hit beats top retire beats a normal step.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            bullet_x <= '0;
            bullet_y <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fire) begin
                        bullet_x <= fire_x;
                        bullet_y <= fire_y;
                        state    <= FLYING;
                    end
                end
                FLYING: begin
                    if (hit) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (bullet_y < STEP10) begin
                            state <= IDLE;
                        end else begin
                            bullet_y <= bullet_y - STEP10;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-stage pixel pipe: address for the ROM, then hit flag lined up with ROM colour.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            read_address <= '0;
            inbox_q1     <= 1'b0;
            is_bullet    <= 1'b0;
        end else begin
            read_address <= addr_next;
            inbox_q1     <= inbox;
            is_bullet    <= inbox_q1;
        end
    end

endmodule

// File: tb/tb_bullet_sprite_ctrl.sv
// Purpose: self-checking bench for bullet_sprite_ctrl: directed scenarios plus randomized run against a behavioural model.
// Latency: model advances one clock per cycle() call; outputs sampled 1 time unit after the rising edge.
// Backpressure: not applicable; stimulus is applied every cycle.
module tb_bullet_sprite_ctrl;

    localparam int SPR_W = 8;
    localparam int SPR_H = 8;
    localparam int STEP  = 4;

    logic        Clk;
    logic        Reset_n;
    logic        frame_clk;
    logic        fire;
    logic [9:0]  fire_x;
    logic [9:0]  fire_y;
    logic        hit;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        busy;
    logic [9:0]  bullet_x;
    logic [9:0]  bullet_y;
    logic [18:0] read_address;
    logic        is_bullet;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state (plain integers).
    bit m_busy;
    int m_x, m_y;
    bit m_fc;
    int m_addr;
    bit m_inq;
    bit m_isb;

    bullet_sprite_ctrl #(.SPR_W(SPR_W), .SPR_H(SPR_H), .STEP(STEP)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_clk    (frame_clk),
        .fire         (fire),
        .fire_x       (fire_x),
        .fire_y       (fire_y),
        .hit          (hit),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .busy         (busy),
        .bullet_x     (bullet_x),
        .bullet_y     (bullet_y),
        .read_address (read_address),
        .is_bullet    (is_bullet)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic model_reset();
        m_busy = 0; m_x = 0; m_y = 0; m_fc = 0;
        m_addr = 0; m_inq = 0; m_isb = 0;
    endtask

    // Advance one clock: model computes next values from current inputs, DUT clocks, then sample point.
    task automatic cycle();
        bit tk, in_box, n_busy;
        int px, py, n_x, n_y, n_addr;
        px = int'(DrawX);
        py = int'(DrawY);
        tk = frame_clk && !m_fc;
        in_box = m_busy && (px >= m_x) && (px < m_x + SPR_W) && (py >= m_y) && (py < m_y + SPR_H);
        n_addr = in_box ? (py - m_y) * SPR_W + (px - m_x) : 0;
        n_busy = m_busy; n_x = m_x; n_y = m_y;
        if (!m_busy) begin
            if (fire) begin
                n_busy = 1; n_x = int'(fire_x); n_y = int'(fire_y);
            end
        end else if (hit) begin
            n_busy = 0;
        end else if (tk) begin
            if (m_y - STEP < 0) n_busy = 0;
            else n_y = m_y - STEP;
        end
        @(posedge Clk);
        #1;
        m_isb = m_inq; m_inq = in_box; m_addr = n_addr;
        m_busy = n_busy; m_x = n_x; m_y = n_y; m_fc = frame_clk;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0; frame_clk = 0; fire = 0; hit = 0;
        fire_x = '0; fire_y = '0; DrawX = '0; DrawY = '0;
        model_reset();
        repeat (3) @(posedge Clk);
        #3;
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    task automatic launch(input int x, input int y);
        fire = 1; fire_x = 10'(x); fire_y = 10'(y);
        cycle();
        fire = 0;
    endtask

    task automatic frame_pulse(input int hi, input int lo);
        frame_clk = 1;
        repeat (hi) cycle();
        frame_clk = 0;
        repeat (lo) cycle();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0d want 0", busy); else n_pass++;
        n_checks++; if (bullet_x !== 10'd0) $display("FAIL reset_x: got %0d want 0", bullet_x); else n_pass++;
        n_checks++; if (bullet_y !== 10'd0) $display("FAIL reset_y: got %0d want 0", bullet_y); else n_pass++;
        n_checks++; if (read_address !== 19'd0) $display("FAIL reset_addr: got %0d want 0", read_address); else n_pass++;
        n_checks++; if (is_bullet !== 1'b0) $display("FAIL reset_isb: got %0d want 0", is_bullet); else n_pass++;
    endtask

    task automatic test_launch_motion();
        do_reset();
        launch(100, 200);
        n_checks++; if (busy !== 1'b1) $display("FAIL launch_busy: got %0d want 1", busy); else n_pass++;
        n_checks++; if (bullet_x !== 10'd100) $display("FAIL launch_x: got %0d want 100", bullet_x); else n_pass++;
        n_checks++; if (bullet_y !== 10'd200) $display("FAIL launch_y: got %0d want 200", bullet_y); else n_pass++;
        for (int i = 0; i < 3; i++) frame_pulse(4, 4);
        n_checks++; if (bullet_y !== 10'd188) $display("FAIL motion_y: got %0d want 188", bullet_y); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL motion_busy: got %0d want 1", busy); else n_pass++;
    endtask

    task automatic test_pixel();
        int ox[4] = '{99, 108, 103, 103};
        int oy[4] = '{205, 205, 199, 208};
        do_reset();
        launch(100, 200);
        DrawX = 10'd103; DrawY = 10'd205;
        cycle();
        n_checks++; if (read_address !== 19'd43) $display("FAIL pix_addr: got %0d want 43", read_address); else n_pass++;
        cycle();
        n_checks++; if (is_bullet !== 1'b1) $display("FAIL pix_isb: got %0d want 1", is_bullet); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            DrawX = 10'(ox[i]); DrawY = 10'(oy[i]);
            cycle(); cycle();
            n_checks++;
            if (read_address !== 19'd0) $display("FAIL pix_out_addr(%0d,%0d): got %0d want 0", ox[i], oy[i], read_address);
            else n_pass++;
            n_checks++;
            if (is_bullet !== 1'b0) $display("FAIL pix_out_isb(%0d,%0d): got %0d want 0", ox[i], oy[i], is_bullet);
            else n_pass++;
        end
    endtask

    task automatic test_top_retire();
        do_reset();
        launch(10, 4);
        frame_pulse(2, 2);
        n_checks++; if (bullet_y !== 10'd0) $display("FAIL top_y0: got %0d want 0", bullet_y); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL top_busy0: got %0d want 1", busy); else n_pass++;
        frame_pulse(2, 2);
        n_checks++; if (busy !== 1'b0) $display("FAIL top_busy1: got %0d want 0", busy); else n_pass++;
        n_checks++; if (bullet_y !== 10'd0) $display("FAIL top_y1: got %0d want 0", bullet_y); else n_pass++;
        launch(10, 3);
        frame_clk = 1;
        cycle();
        n_checks++; if (busy !== 1'b0) $display("FAIL top3_busy: got %0d want 0", busy); else n_pass++;
        n_checks++; if (bullet_y !== 10'd3) $display("FAIL top3_y: got %0d want 3", bullet_y); else n_pass++;
        frame_clk = 0;
        cycle();
    endtask

    task automatic test_simultaneous();
        do_reset();
        launch(100, 200);
        hit = 1; frame_clk = 1;
        cycle();
        hit = 0; frame_clk = 0;
        n_checks++; if (busy !== 1'b0) $display("FAIL hit_tick_busy: got %0d want 0", busy); else n_pass++;
        n_checks++; if (bullet_y !== 10'd200) $display("FAIL hit_tick_y: got %0d want 200", bullet_y); else n_pass++;
        cycle();
        fire = 1; fire_x = 10'd100; fire_y = 10'd200; frame_clk = 1;
        cycle();
        fire = 0;
        n_checks++; if (bullet_y !== 10'd200) $display("FAIL fire_tick_y: got %0d want 200", bullet_y); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL fire_tick_busy: got %0d want 1", busy); else n_pass++;
        cycle();
        n_checks++; if (bullet_y !== 10'd200) $display("FAIL fire_tick_hold: got %0d want 200", bullet_y); else n_pass++;
        frame_clk = 0;
        launch(50, 60);
        n_checks++; if (bullet_x !== 10'd100) $display("FAIL refire_x: got %0d want 100", bullet_x); else n_pass++;
        n_checks++; if (bullet_y !== 10'd200) $display("FAIL refire_y: got %0d want 200", bullet_y); else n_pass++;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        launch(100, 200);
        DrawX = 10'd103; DrawY = 10'd205;
        repeat (5) cycle();
        n_checks++; if (read_address !== 19'd43) $display("FAIL mid_pre_addr: got %0d want 43", read_address); else n_pass++;
        #2;
        Reset_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy: got %0d want 0", busy); else n_pass++;
        n_checks++; if (bullet_x !== 10'd0) $display("FAIL mid_x: got %0d want 0", bullet_x); else n_pass++;
        n_checks++; if (bullet_y !== 10'd0) $display("FAIL mid_y: got %0d want 0", bullet_y); else n_pass++;
        n_checks++; if (read_address !== 19'd0) $display("FAIL mid_addr: got %0d want 0", read_address); else n_pass++;
        n_checks++; if (is_bullet !== 1'b0) $display("FAIL mid_isb: got %0d want 0", is_bullet); else n_pass++;
        do_reset();
    endtask

    task automatic test_random();
        int bad = 0;
        int off;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            fire   = ($urandom_range(0, 15) == 0);
            fire_x = 10'($urandom_range(0, 1000));
            fire_y = 10'($urandom_range(0, 1000));
            hit    = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) frame_clk = ~frame_clk;
            if ($urandom_range(0, 7) == 0) begin
                DrawX = 10'($urandom_range(0, 1023));
                DrawY = 10'($urandom_range(0, 1023));
            end else begin
                off = m_x + $urandom_range(0, 11) - 2;
                DrawX = 10'((off < 0) ? 0 : off);
                off = m_y + $urandom_range(0, 11) - 2;
                DrawY = 10'((off < 0) ? 0 : off);
            end
            cycle();
            n_checks++;
            if (busy !== m_busy || bullet_x !== 10'(m_x) || bullet_y !== 10'(m_y)) begin
                if (bad < 10) $display("FAIL rand_state cyc %0d: got busy=%0d x=%0d y=%0d want busy=%0d x=%0d y=%0d",
                                       i, busy, bullet_x, bullet_y, m_busy, m_x, m_y);
                bad++;
            end else n_pass++;
            n_checks++;
            if (read_address !== 19'(m_addr)) begin
                if (bad < 10) $display("FAIL rand_addr cyc %0d: got %0d want %0d", i, read_address, m_addr);
                bad++;
            end else n_pass++;
            n_checks++;
            if (is_bullet !== m_isb) begin
                if (bad < 10) $display("FAIL rand_isb cyc %0d: got %0d want %0d", i, is_bullet, m_isb);
                bad++;
            end else n_pass++;
        end
        fire = 0; hit = 0;
    endtask

    initial begin
        Reset_n = 1'b0; frame_clk = 0; fire = 0; hit = 0;
        fire_x = '0; fire_y = '0; DrawX = '0; DrawY = '0;
        model_reset();
        test_reset();
        test_launch_motion();
        test_pixel();
        test_top_retire();
        test_simultaneous();
        test_reset_midflight();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
